// File: rtl/whack_pkg.sv
// Shared whack-a-mole definitions: game state encoding, display widths and
// the LFSR feedback mask reused by the display, VGA and speed-ramp stages.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        UP    = 2'd2,
        DONE  = 2'd3
    } game_state_t;

    localparam int SCORE_W = 8;
    localparam int TIME_W  = 7;

    // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_POLY = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        lfsr_next = {1'b0, s[7:1]} ^ (s[0] ? LFSR_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR; a maximal-length polynomial means a nonzero
// seed never reaches the all-zero lock-up state.
module lfsr8
    import whack_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       ClockIn,
    input  logic       Reset,
    output logic [7:0] State
);

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            State <= SEED;
        end else begin
            State <= lfsr_next(State);
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Game sequencer: runs the countdown and mole-up timers from the 1 Hz Tick,
// picks holes from the LFSR and scores rising edges on the hit buttons.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int         NUM_HOLES     = 4,
    parameter int         GAME_SECONDS  = 60,
    parameter int         MOLE_UP_TICKS = 2,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                 ClockIn,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 Start,
    input  logic [NUM_HOLES-1:0] Hit,
    output logic [NUM_HOLES-1:0] MoleOut,
    output logic [SCORE_W-1:0]   Score,
    output logic [TIME_W-1:0]    TimeLeft,
    output logic                 Busy,
    output logic                 GameOver,
    output game_state_t          StateDbg
);

    localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(GAME_SECONDS);
    localparam logic [3:0]        UP_INIT   = 4'(MOLE_UP_TICKS);
    localparam logic [3:0]        HOLES4    = 4'(NUM_HOLES);
    localparam logic [2:0]        LAST_HOLE = 3'(NUM_HOLES - 1);

    game_state_t          state_q, state_d;
    logic [NUM_HOLES-1:0] mole_q, mole_d, hit_q, hit_rise, mole_spawn;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic [3:0]           up_q, up_d;
    logic [2:0]           prev_q, prev_d, cand, chosen;
    logic [7:0]           lfsr;
    logic                 active_rise, wrong_rise;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .State   (lfsr)
    );

    // Hit history runs in every state so a button held through Start never scores.
    assign hit_rise    = Hit & ~hit_q;
    assign active_rise = |(hit_rise & mole_q);
    assign wrong_rise  = |(hit_rise & ~mole_q) && !active_rise;

    always_comb begin
        cand   = 3'(lfsr[3:0] % HOLES4);
        chosen = cand;
        if (cand == prev_q) begin
            chosen = (cand == LAST_HOLE) ? 3'd0 : cand + 3'd1;
        end
        mole_spawn = {{(NUM_HOLES-1){1'b0}}, 1'b1} << chosen;
    end

    always_comb begin
        state_d = state_q;
        mole_d  = mole_q;
        score_d = score_q;
        time_d  = time_q;
        up_d    = up_q;
        prev_d  = prev_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = SPAWN;
                    score_d = '0;
                    time_d  = TIME_INIT;
                    mole_d  = '0;
                end
            end
            SPAWN: begin
                mole_d  = mole_spawn;
                up_d    = UP_INIT;
                prev_d  = chosen;
                state_d = UP;
            end
            UP: begin
                if (active_rise) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    mole_d  = '0;
                    state_d = SPAWN;
                end else begin
                    if (wrong_rise && score_q != 8'd0) begin
                        score_d = score_q - 8'd1;
                    end
                    if (Tick) begin
                        up_d = up_q - 4'd1;
                        if (up_q == 4'd1) begin
                            mole_d  = '0;
                            state_d = SPAWN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The game clock runs after scoring and overrides any mole transition.
        if ((state_q == SPAWN || state_q == UP) && Tick) begin
            time_d = time_q - 7'd1;
            if (time_q == 7'd1) begin
                time_d  = '0;
                mole_d  = '0;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q <= IDLE;
            mole_q  <= '0;
            score_q <= '0;
            time_q  <= TIME_INIT;
            up_q    <= '0;
            prev_q  <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            time_q  <= time_d;
            up_q    <= up_d;
            prev_q  <= prev_d;
            hit_q   <= Hit;
        end
    end

    assign MoleOut  = mole_q;
    assign Score    = score_q;
    assign TimeLeft = time_q;
    assign Busy     = (state_q == SPAWN) || (state_q == UP);
    assign GameOver = (state_q == DONE);
    assign StateDbg = state_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: a reset/idle vector table followed by
// hand-written game sequences with a reference LFSR predicting each hole.
module tb_mole_scheduler;
    import whack_pkg::*;

    localparam int         NH   = 4;
    localparam int         GS   = 60;
    localparam int         MU   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic          ClockIn = 1'b0;
    logic          Reset, Tick, Start;
    logic [NH-1:0] Hit;
    logic [NH-1:0] MoleOut;
    logic [7:0]    Score;
    logic [6:0]    TimeLeft;
    logic          Busy, GameOver;
    game_state_t   StateDbg;

    mole_scheduler #(
        .NUM_HOLES     (NH),
        .GAME_SECONDS  (GS),
        .MOLE_UP_TICKS (MU),
        .LFSR_SEED     (SEED)
    ) dut (
        .ClockIn  (ClockIn),
        .Reset    (Reset),
        .Tick     (Tick),
        .Start    (Start),
        .Hit      (Hit),
        .MoleOut  (MoleOut),
        .Score    (Score),
        .TimeLeft (TimeLeft),
        .Busy     (Busy),
        .GameOver (GameOver),
        .StateDbg (StateDbg)
    );

    // clock / reference LFSR
    always #10 ClockIn = ~ClockIn;

    function automatic logic [7:0] model_next(input logic [7:0] s);
        logic fb;
        fb = s[0];
        model_next = {fb, s[7], s[6] ^ fb, s[5] ^ fb, s[4] ^ fb, s[3], s[2], s[1]};
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge ClockIn) m_lfsr <= Reset ? SEED : model_next(m_lfsr);

    // scoreboard state
    int            checks = 0;
    int            errors = 0;
    logic [NH-1:0] exp_q[$];
    logic [NH-1:0] exp_mole;
    logic [7:0]    exp_score;
    logic [6:0]    exp_time;
    game_state_t   exp_state;
    logic [2:0]    m_prev;
    int            cur_hole;

    typedef struct {
        logic          rst;
        logic          start;
        logic          tick;
        logic [NH-1:0] hit;
        game_state_t   st;
        logic [7:0]    score;
        logic [6:0]    tl;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [NH-1:0] onehot(input int h);
        onehot = '0;
        onehot[h] = 1'b1;
    endfunction

    task automatic step();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name);
        check({name, "/state"}, StateDbg, exp_state);
        check({name, "/mole"}, MoleOut, exp_mole);
        check({name, "/score"}, Score, exp_score);
        check({name, "/time"}, TimeLeft, exp_time);
        check({name, "/busy"}, Busy, (exp_state == SPAWN || exp_state == UP));
        check({name, "/gameover"}, GameOver, (exp_state == DONE));
    endtask

    // Called while the DUT sits in SPAWN: the hole it will pick is a function
    // of the LFSR value it holds right now and the previous hole.
    task automatic predict();
        logic [2:0] c;
        c = 3'(int'(m_lfsr[3:0]) % NH);
        if (c == m_prev) c = (int'(c) == NH - 1) ? 3'd0 : c + 3'd1;
        m_prev   = c;
        cur_hole = int'(c);
        exp_q.push_back(onehot(cur_hole));
    endtask

    task automatic spawn_step(input string name);
        step();
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no predicted hole queued", name);
        end else begin
            exp_mole = exp_q.pop_front();
        end
        exp_state = UP;
        check_all(name);
    endtask

    task automatic correct_hit(input string name);
        Hit = onehot(cur_hole);
        step();
        exp_score = (exp_score == 8'hFF) ? 8'hFF : exp_score + 8'd1;
        exp_mole  = '0;
        exp_state = SPAWN;
        check_all(name);
        predict();
        Hit = '0;
        spawn_step({name, "/respawn"});
    endtask

    task automatic wrong_hit(input string name, input logic [NH-1:0] mask);
        Hit = mask;
        step();
        exp_score = (exp_score == 8'd0) ? 8'd0 : exp_score - 8'd1;
        exp_state = UP;
        check_all(name);
        Hit = '0;
        step();
        check_all({name, "/release"});
    endtask

    task automatic timeout(input string name);
        Tick = 1'b1;
        step();
        exp_time  = exp_time - 7'd1;
        exp_state = UP;
        check_all({name, "/tick1"});
        step();
        exp_time  = exp_time - 7'd1;
        exp_state = SPAWN;
        exp_mole  = '0;
        check_all({name, "/tick2"});
        Tick = 1'b0;
        predict();
        spawn_step({name, "/respawn"});
    endtask

    // Correct hit then wrong hit: score is unchanged but a new hole comes up.
    task automatic find_hole(input int target);
        for (int i = 0; i < 60 && cur_hole != target; i++) begin
            correct_hit("seek_hit");
            wrong_hit("seek_wrong", ~onehot(cur_hole));
        end
        check("find_hole", cur_hole, target);
    endtask

    initial begin
        Reset = 1'b0; Tick = 1'b0; Start = 1'b0; Hit = '0;
        m_prev = '0; cur_hole = 0;
        exp_mole = '0; exp_score = '0; exp_time = 7'(GS); exp_state = IDLE;

        // rst start tick hit     state  score tl
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, IDLE,  8'd0, 7'd60};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'b0000, IDLE,  8'd0, 7'd60};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 4'b0000, IDLE,  8'd0, 7'd60};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 4'b0100, IDLE,  8'd0, 7'd60};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 4'b0100, IDLE,  8'd0, 7'd60};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 4'b0100, SPAWN, 8'd0, 7'd60};

        for (int i = 0; i < 6; i++) begin
            Reset = vecs[i].rst;
            Start = vecs[i].start;
            Tick  = vecs[i].tick;
            Hit   = vecs[i].hit;
            if (vecs[i].rst) begin
                m_prev = '0;
                exp_q.delete();
            end
            step();
            exp_state = vecs[i].st;
            exp_score = vecs[i].score;
            exp_time  = vecs[i].tl;
            exp_mole  = '0;
            check_all($sformatf("vec%0d", i));
        end
        Reset = 1'b0; Start = 1'b0; Tick = 1'b0;

        // First spawn with Hit[2] still held from before Start: no score.
        predict();
        spawn_step("first_spawn");
        Hit = '0;
        step();
        check_all("held_release");

        // Correct hit on hole 2, then keep holding the button.
        find_hole(2);
        Hit = onehot(2);
        step();
        exp_score = exp_score + 8'd1;
        exp_mole  = '0;
        exp_state = SPAWN;
        check_all("hit_hole2");
        check("score_0_to_1", Score, 8'd1);
        predict();
        spawn_step("hit_hole2_respawn");
        step();
        check_all("hit_hole2_held");
        Hit = '0;
        step();
        check_all("hit_hole2_release");

        // Wrong hits: decrement from 1, then two wrong bits at score 0 on hole 3.
        wrong_hit("wrong_dec", ~onehot(cur_hole));
        find_hole(3);
        wrong_hit("wrong_two_at_zero", 4'b0011);

        // Climb to saturation; also covers a few hundred no-repeat spawns.
        for (int i = 0; i < 255; i++) correct_hit("climb");
        check("score_255", Score, 8'd255);
        wrong_hit("wrong_multi_once", ~onehot(cur_hole));
        check("score_254", Score, 8'd254);
        correct_hit("back_to_255");
        correct_hit("sat_255");
        check("score_sat", Score, 8'd255);

        // Timeouts burn the clock down to the final seconds.
        timeout("timeout");
        check("time_58", TimeLeft, 7'd58);
        while (exp_time > 7'd2) timeout("burn");
        Tick = 1'b1;
        step();
        Tick = 1'b0;
        exp_time = 7'd1;
        check_all("time_1");
        wrong_hit("pre_final_wrong", ~onehot(cur_hole));

        // Correct hit lands on the same cycle as the last Tick.
        Hit  = onehot(cur_hole);
        Tick = 1'b1;
        step();
        exp_score = 8'd255;
        exp_time  = '0;
        exp_mole  = '0;
        exp_state = DONE;
        check_all("final_tick_hit");
        Hit = '0;
        step();
        Tick = 1'b0;
        check_all("done_tick_ignored");

        // Restart from DONE.
        Start = 1'b1;
        step();
        Start = 1'b0;
        exp_score = '0;
        exp_time  = 7'(GS);
        exp_state = SPAWN;
        check_all("restart");
        predict();
        spawn_step("restart_spawn");

        // Reset mid-game at TimeLeft=30, Score=5.
        for (int i = 0; i < 5; i++) correct_hit("mid_hit");
        for (int i = 0; i < 15; i++) timeout("mid_burn");
        check("mid_score", Score, 8'd5);
        check("mid_time", TimeLeft, 7'd30);
        Reset = 1'b1;
        m_prev = '0;
        exp_q.delete();
        step();
        Reset = 1'b0;
        exp_score = '0;
        exp_time  = 7'(GS);
        exp_mole  = '0;
        exp_state = IDLE;
        check_all("mid_reset");
        Start = 1'b1;
        step();
        Start = 1'b0;
        exp_state = SPAWN;
        check_all("post_reset_start");
        predict();
        spawn_step("post_reset_spawn");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game-sequencing stage directly downstream of the 1 Hz rate divider. It consumes the divider's one-cycle `Tick` pulse to run the game countdown and the mole-up timers. It picks the next hole with a free-running LFSR and scores player hits. Its outputs drive the hole LEDs/VGA renderer and the score/time display.

## Interface
- `NUM_HOLES`, default 4: number of holes; range 2..8.
- `GAME_SECONDS`, default 60: game length in Ticks; range 1..127.
- `MOLE_UP_TICKS`, default 2: Ticks a mole stays up; range 1..15.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

- `ClockIn`  in  1  system clock, 50 MHz.
- `Reset`  in  1  synchronous, active-high reset.
- `Tick`  in  1  one-cycle enable pulse from the rate divider.
- `Start`  in  1  level; sampled in IDLE/DONE to begin a game.
- `Hit`  in  NUM_HOLES  debounced, synchronized button levels. Rising edges are detected internally.
- `MoleOut`  out  NUM_HOLES  one-hot active hole; all zero when no mole is up.
- `Score`  out  8  current score, saturating.
- `TimeLeft`  out  7  remaining game seconds.
- `Busy`  out  1  high while in SPAWN or UP.
- `GameOver`  out  1  high in DONE.

## Operation
- States are IDLE, SPAWN, UP and DONE. Reset forces IDLE.
- **Reset values:** MoleOut=0, Score=0, TimeLeft=GAME_SECONDS, Busy=0, GameOver=0, LFSR=LFSR_SEED, previous hole=0, Hit history=0.
- **IDLE:** Start=1 → SPAWN. On that transition, Score←0 and TimeLeft←GAME_SECONDS.
- **SPAWN:** lasts exactly one cycle.
  - The candidate hole is LFSR[3:0] mod NUM_HOLES.
  - If the candidate equals the previous hole, use (candidate+1) mod NUM_HOLES.
  - Set MoleOut to the one-hot of the chosen hole, load up_cnt←MOLE_UP_TICKS, store the previous hole, then go to UP.
- **UP, hit on the active hole:** a rising edge on Hit[active] gives Score+1 (holds at 255), MoleOut←0, then → SPAWN.
- **UP, wrong hole:** a rising edge on any other bit while the active bit has no rising edge gives Score−1 (holds at 0). The state stays UP. Several wrong bits rising in the same cycle count as one penalty.
- **UP, Tick:** up_cnt decrements. If up_cnt was 1, MoleOut←0 and → SPAWN (timeout, no score change).
- **Tick in SPAWN or UP:** TimeLeft decrements. If TimeLeft was 1, then TimeLeft←0, MoleOut←0 and → DONE. This overrides any SPAWN/UP transition.
- **Hit and Tick in the same cycle:** the hit is scored first, then the Tick is applied. A hit on the final Tick still counts.
- **DONE:** GameOver=1, Score and TimeLeft are held. Start=1 → SPAWN with Score←0 and TimeLeft←GAME_SECONDS.
- **LFSR:** 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle in every state and never reaches zero.
- **Hit detection:** edge = Hit & ~Hit_q. Hit_q updates every cycle, including in IDLE and DONE, so a button held through Start does not score.
- **Tick in IDLE or DONE:** ignored.

## Timing
- All outputs are registered. Changes appear the cycle after the causing input is sampled.
- Start sampled at edge N: Busy=1 and Score=0 at N+1, MoleOut valid at N+2 (after SPAWN).
- Tick sampled at edge N: TimeLeft and up_cnt are updated at N+1.
- Hit edge sampled at edge N: Score and MoleOut=0 at N+1, new MoleOut at N+2.
- Minimum mole visibility is 1 cycle. Maximum is MOLE_UP_TICKS Ticks.
- Reset mid-game: the next cycle shows IDLE and every output at its reset value. No partial score is kept.

## Structure
- **Shared package `whack_pkg`:** the state enum (IDLE, SPAWN, UP, DONE), the score width (8), the time width (7) and the LFSR polynomial constant. The display and VGA stages reuse these.
- **Sub-module `lfsr8`:** ports ClockIn, Reset, seed parameter and an 8-bit state output. It is reused later for the mole-speed ramp.
- Hole select, edge detect and the FSM stay inline.

## Test plan
- **Reset:** assert Reset for 2 cycles, then release → MoleOut=0, Score=0, TimeLeft=60, Busy=0, GameOver=0. With Start=0 and any Ticks, the block stays in IDLE.
- **Start and spawn:** Start pulse → Busy=1 next cycle, exactly one MoleOut bit set two cycles after Start. Across 200 spawns, no hole repeats back-to-back.
- **Correct hit:** with mole on hole 2, raise Hit[2] → Score 0→1 and MoleOut=0 one cycle later. Holding Hit[2] high adds nothing further.
- **Wrong hit and saturation:**
  - Score=0, raise Hit[0] and Hit[1] together while hole 3 is up → Score stays 0, state stays UP.
  - Score=255, correct hit → Score stays 255.
- **Timeout and game end:**
  - MOLE_UP_TICKS=2, no hits → new spawn after the 2nd Tick.
  - After 60 Ticks → TimeLeft=0, GameOver=1, MoleOut=0, Busy=0.
  - A correct hit in the same cycle as the 60th Tick still increments Score.
- **Restart:** Start in DONE → Score=0, TimeLeft=60, GameOver=0.
- **Reset mid-game:** Reset with TimeLeft=30 and Score=5 → all outputs at reset values the next cycle.
